// File: rtl/uart_tx.sv
// ============================================================================
// Module      : uart_tx
// Description : Memory-mapped 8N1 UART transmitter with a small transmit
//               FIFO. DATA register (addr[2]=0) accepts bytes to send,
//               STATUS register (addr[2]=1) reports FIFO/frame state and a
//               sticky overflow flag that is cleared by any STATUS write.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DEPTH        = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sel,
  input  logic [13:0] addr,
  input  logic        rstrb,
  input  logic        wstrb,
  input  logic [31:0] wdata,
  input  logic [1:0]  wsize,
  output logic [31:0] rdata,
  output logic        tx,
  output logic        busy
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int c_PTR_W  = $clog2(DEPTH);
  localparam int c_CNT_W  = $clog2(DEPTH + 1);
  localparam int c_BAUD_W = 16;

  localparam logic [c_CNT_W-1:0]  c_FULL_CNT  = c_CNT_W'(DEPTH);
  localparam logic [c_BAUD_W-1:0] c_BAUD_LOAD = c_BAUD_W'(CLKS_PER_BIT - 1);

  localparam logic [1:0] c_ST_IDLE  = 2'd0;
  localparam logic [1:0] c_ST_START = 2'd1;
  localparam logic [1:0] c_ST_DATA  = 2'd2;
  localparam logic [1:0] c_ST_STOP  = 2'd3;

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  logic [7:0]          r_mem [DEPTH];
  logic [c_PTR_W-1:0]  r_wptr;
  logic [c_PTR_W-1:0]  r_rptr;
  logic [c_CNT_W-1:0]  r_count;
  logic                r_ovf;

  logic [1:0]          r_state;
  logic [c_BAUD_W-1:0] r_baud;
  logic [2:0]          r_bit_idx;
  logic [7:0]          r_shift;
  logic                r_tx;
  logic [31:0]         r_rdata;

  // --------------------------------------------------------------------------
  // Combinational wires
  // --------------------------------------------------------------------------
  logic        w_full;
  logic        w_empty;
  logic        w_data_wr;
  logic        w_stat_wr;
  logic        w_push;
  logic        w_pop;
  logic        w_ovf_set;
  logic        w_bit_end;
  logic        w_shift_out;
  logic        w_stop_go;
  logic        w_frame_active;
  logic [1:0]  w_state_nxt;
  logic [7:0]  w_head;
  logic [31:0] w_status;
  logic        w_unused_bits;

  // Only addr[2] and the low data byte carry meaning; the rest is decoded away.
  assign w_unused_bits = ^{addr[13:3], addr[1:0], wdata[31:8], wsize};

  assign w_full  = (r_count == c_FULL_CNT);
  assign w_empty = (r_count == '0);
  assign w_head  = r_mem[r_rptr];

  // Bus decode: strobes count only while selected.
  assign w_data_wr = sel && wstrb && !addr[2];
  assign w_stat_wr = sel && wstrb &&  addr[2];

  // A push into a full FIFO is still taken when the head leaves the same cycle.
  assign w_push    = w_data_wr && (!w_full || w_pop);
  assign w_ovf_set = w_data_wr &&   w_full && !w_pop;

  assign w_bit_end = (r_baud == '0);

  assign w_status = {16'h0000, 8'(r_count), 4'h0,
                     r_ovf, w_frame_active, w_empty, w_full};

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  // Reset forces IDLE so an in-flight frame is abandoned on the spot.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= c_ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM next-state logic
  // --------------------------------------------------------------------------
  // Each non-idle state lasts until the baud counter has run down to zero.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_IDLE:  if (!w_empty)                        w_state_nxt = c_ST_START;
      c_ST_START: if (w_bit_end)                       w_state_nxt = c_ST_DATA;
      c_ST_DATA:  if (w_bit_end && r_bit_idx == 3'd7)  w_state_nxt = c_ST_STOP;
      c_ST_STOP:  if (w_bit_end)                       w_state_nxt = c_ST_IDLE;
      default:                                         w_state_nxt = c_ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM output logic
  // --------------------------------------------------------------------------
  // Datapath controls: pop a byte, emit the next data bit, or enter the stop bit.
  always_comb begin
    w_pop          = 1'b0;
    w_shift_out    = 1'b0;
    w_stop_go      = 1'b0;
    w_frame_active = 1'b1;
    case (r_state)
      c_ST_IDLE: begin
        w_frame_active = 1'b0;
        // Uses the registered count, so a byte pushed this cycle waits one edge.
        w_pop          = !w_empty;
      end
      c_ST_START: begin
        w_shift_out = w_bit_end;
      end
      c_ST_DATA: begin
        w_shift_out = w_bit_end && (r_bit_idx != 3'd7);
        w_stop_go   = w_bit_end && (r_bit_idx == 3'd7);
      end
      c_ST_STOP: begin
        w_shift_out = 1'b0;
      end
      default: begin
        w_frame_active = 1'b0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Serial datapath: baud counter, shifter, bit index and registered tx
  // --------------------------------------------------------------------------
  // tx is always a flop output; the bit index wraps 7->0 on the last data bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tx      <= 1'b1;
      r_baud    <= '0;
      r_bit_idx <= 3'd0;
      r_shift   <= 8'h00;
    end else if (w_pop) begin
      r_shift   <= w_head;
      r_tx      <= 1'b0;
      r_baud    <= c_BAUD_LOAD;
    end else if (w_shift_out) begin
      r_tx      <= r_shift[0];
      r_shift   <= {1'b0, r_shift[7:1]};
      r_baud    <= c_BAUD_LOAD;
      if (r_state == c_ST_DATA) begin
        r_bit_idx <= r_bit_idx + 3'd1;
      end
    end else if (w_stop_go) begin
      r_tx      <= 1'b1;
      r_baud    <= c_BAUD_LOAD;
      r_bit_idx <= r_bit_idx + 3'd1;
    end else if (w_frame_active && !w_bit_end) begin
      r_baud    <= r_baud - c_BAUD_W'(1);
    end
  end

  // --------------------------------------------------------------------------
  // Transmit FIFO storage
  // --------------------------------------------------------------------------
  // Storage needs no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (!reset && w_push) begin
      r_mem[r_wptr] <= wdata[7:0];
    end
  end

  // --------------------------------------------------------------------------
  // Transmit FIFO pointers, count and sticky overflow
  // --------------------------------------------------------------------------
  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + c_PTR_W'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + c_PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CNT_W'(1);
        2'b01:   r_count <= r_count - c_CNT_W'(1);
        default: r_count <= r_count;
      endcase
      if (w_ovf_set) begin
        r_ovf <= 1'b1;
      end else if (w_stat_wr) begin
        r_ovf <= 1'b0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Registered read data
  // --------------------------------------------------------------------------
  // One-cycle read latency like a synchronous RAM; held between reads.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rdata <= 32'h0000_0000;
    end else if (sel && rstrb) begin
      r_rdata <= addr[2] ? w_status : 32'h0000_0000;
    end
  end

  assign rdata = r_rdata;
  assign tx    = r_tx;
  assign busy  = w_frame_active || !w_empty;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx.sv
// ============================================================================
// Module      : tb_uart_tx
// Description : Self-checking bench for uart_tx (CLKS_PER_BIT=4, DEPTH=4).
//               A queue-based reference model predicts tx, busy and rdata
//               every cycle; directed tables and sequences add fixed values.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic        sel   = 1'b0;
  logic [13:0] addr  = 14'h0;
  logic        rstrb = 1'b0;
  logic        wstrb = 1'b0;
  logic [31:0] wdata = 32'h0;
  logic [1:0]  wsize = 2'b0;
  logic [31:0] rdata;
  logic        tx;
  logic        busy;

  int checks = 0;
  int errors = 0;

  uart_tx #(.CLKS_PER_BIT(CPB), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .sel   (sel),
    .addr  (addr),
    .rstrb (rstrb),
    .wstrb (wstrb),
    .wdata (wdata),
    .wsize (wsize),
    .rdata (rdata),
    .tx    (tx),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  // Reference model: queued bytes plus a cycle offset inside the current frame.
  logic [7:0]  m_q[$];
  bit          m_act  = 1'b0;
  int          m_t    = 0;
  logic [7:0]  m_cur  = 8'h00;
  bit          m_ovf  = 1'b0;
  logic [31:0] m_rdata = 32'h0;

  function automatic logic m_tx();
    int b;
    if (!m_act)        return 1'b1;
    if (m_t < CPB)     return 1'b0;
    if (m_t < 9 * CPB) begin
      b = m_t / CPB - 1;
      return m_cur[b[2:0]];
    end
    return 1'b1;
  endfunction

  function automatic logic m_busy();
    return m_act || (m_q.size() != 0);
  endfunction

  // Advance the model by one clock edge using the inputs now on the bus.
  task automatic model_step();
    logic [31:0] st;
    bit          do_pop;
    if (reset) begin
      m_q.delete();
      m_act   = 1'b0;
      m_t     = 0;
      m_ovf   = 1'b0;
      m_rdata = 32'h0;
      return;
    end
    st        = 32'h0;
    st[15:8]  = 8'(m_q.size());
    st[3]     = m_ovf;
    st[2]     = m_act;
    st[1]     = (m_q.size() == 0);
    st[0]     = (m_q.size() == DEPTH);
    do_pop    = !m_act && (m_q.size() != 0);
    if (m_act) begin
      m_t = m_t + 1;
      if (m_t == 10 * CPB) m_act = 1'b0;
    end
    if (do_pop) begin
      m_cur = m_q.pop_front();
      m_act = 1'b1;
      m_t   = 0;
    end
    if (sel && wstrb) begin
      if (!addr[2]) begin
        if (m_q.size() < DEPTH) m_q.push_back(wdata[7:0]);
        else                    m_ovf = 1'b1;
      end else begin
        m_ovf = 1'b0;
      end
    end
    if (sel && rstrb) m_rdata = addr[2] ? st : 32'h0;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // One bus cycle: drive at negedge, step the model, compare after the edge.
  task automatic cyc(input bit r, input bit s, input bit rd, input bit wr,
                     input bit a2, input logic [31:0] wd);
    logic [13:0] a;
    a      = 14'($urandom);
    a[2]   = a2;
    reset  = r;
    sel    = s;
    rstrb  = rd;
    wstrb  = wr;
    addr   = a;
    wdata  = wd;
    wsize  = 2'($urandom);
    model_step();
    @(negedge clk);
    chk("model_tx",    32'(tx),   32'(m_tx()));
    chk("model_busy",  32'(busy), 32'(m_busy()));
    chk("model_rdata", rdata,     m_rdata);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  typedef struct {
    bit          rst;
    bit          s;
    bit          rd;
    bit          wr;
    bit          a2;
    logic [31:0] wd;
    logic [31:0] er;
    bit          eb;
    bit          et;
  } vec_t;

  vec_t        tbl[16];
  logic [39:0] wave;
  logic        smp[0:90];
  int          falls;
  int          fall1;
  int          fall2;
  int          run;
  int          lows;

  initial begin
    // rst s rd wr a2 wdata   | rdata  busy tx
    tbl[0]  = '{1, 0, 0, 0, 0, 32'h0,        32'h0000_0000, 0, 1};
    tbl[1]  = '{0, 1, 1, 0, 1, 32'h0,        32'h0000_0002, 0, 1};
    tbl[2]  = '{0, 1, 0, 1, 0, 32'h0000_0001, 32'h0000_0002, 1, 1};
    tbl[3]  = '{0, 1, 0, 1, 0, 32'hFFFF_FF02, 32'h0000_0002, 1, 0};
    tbl[4]  = '{0, 1, 0, 1, 0, 32'h0000_0003, 32'h0000_0002, 1, 0};
    tbl[5]  = '{0, 1, 0, 1, 0, 32'h1234_5604, 32'h0000_0002, 1, 0};
    tbl[6]  = '{0, 1, 0, 1, 0, 32'h0000_0005, 32'h0000_0002, 1, 0};
    tbl[7]  = '{0, 1, 1, 0, 1, 32'h0,        32'h0000_0405, 1, 1};
    tbl[8]  = '{0, 0, 1, 1, 0, 32'h0000_0077, 32'h0000_0405, 1, 1};
    tbl[9]  = '{0, 1, 1, 0, 0, 32'h0,        32'h0000_0000, 1, 1};
    tbl[10] = '{0, 1, 0, 1, 0, 32'h0000_00AA, 32'h0000_0000, 1, 1};
    tbl[11] = '{0, 1, 1, 0, 1, 32'h0,        32'h0000_040D, 1, 0};
    tbl[12] = '{0, 1, 0, 1, 1, 32'hFFFF_FFFF, 32'h0000_040D, 1, 0};
    tbl[13] = '{0, 1, 1, 0, 1, 32'h0,        32'h0000_0405, 1, 0};
    tbl[14] = '{1, 1, 1, 1, 0, 32'h0000_0099, 32'h0000_0000, 0, 1};
    tbl[15] = '{0, 1, 1, 0, 1, 32'h0,        32'h0000_0002, 0, 1};

    @(negedge clk);

    // Directed table: fill, overflow, clear, sel gating, DATA read, reset priority.
    for (int i = 0; i < 16; i++) begin
      cyc(tbl[i].rst, tbl[i].s, tbl[i].rd, tbl[i].wr, tbl[i].a2, tbl[i].wd);
      chk($sformatf("tbl%0d_rdata", i), rdata,     tbl[i].er);
      chk($sformatf("tbl%0d_busy",  i), 32'(busy), 32'(tbl[i].eb));
      chk($sformatf("tbl%0d_tx",    i), 32'(tx),   32'(tbl[i].et));
    end

    // Single 0x55 frame: start, alternating data bits, stop, then busy drops.
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h55);
    wave = 40'b0000_1111_0000_1111_0000_1111_0000_1111_0000_1111;
    for (int k = 1; k <= 41; k++) begin
      idle(1);
      if (k <= 40) chk($sformatf("frame55_c%0d", k), 32'(tx), 32'(wave[40 - k]));
      if (k == 40) chk("frame55_busy_c40", 32'(busy), 32'd1);
      if (k == 41) chk("frame55_busy_c41", 32'(busy), 32'd0);
    end

    // Back-to-back 0x00 and 0xFF: exactly one idle cycle beyond the stop bit.
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h00);
    smp[0] = tx;
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'hFF);
    smp[1] = tx;
    for (int k = 2; k <= 90; k++) begin
      idle(1);
      smp[k] = tx;
      if (k == 81) chk("b2b_busy_c81", 32'(busy), 32'd1);
      if (k == 82) chk("b2b_busy_c82", 32'(busy), 32'd0);
    end
    falls = 0; fall1 = -1; fall2 = -1;
    for (int k = 1; k <= 90; k++) begin
      if (smp[k - 1] && !smp[k]) begin
        falls = falls + 1;
        if (falls == 1) fall1 = k;
        if (falls == 2) fall2 = k;
      end
    end
    run = 0;
    if (fall2 > 0) begin
      for (int k = fall2 - 1; k >= 0 && smp[k]; k--) run = run + 1;
    end
    chk("b2b_falls",      32'(falls), 32'd2);
    chk("b2b_first_fall", 32'(fall1), 32'd1);
    chk("b2b_second_fall",32'(fall2), 32'd42);
    chk("b2b_high_run",   32'(run),   32'(CPB + 1));

    // Reset during DATA with two bytes queued: frame aborted, queue discarded.
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h3C);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'hA5);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h5A);
    idle(9);
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h11);
    chk("abort_tx",   32'(tx),   32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0);
    chk("abort_status", rdata, 32'h0000_0002);
    lows = 0;
    for (int k = 0; k < 60; k++) begin
      idle(1);
      if (!tx) lows = lows + 1;
    end
    chk("abort_no_frames", 32'(lows), 32'd0);

    // Randomized traffic against the reference model.
    for (int n = 0; n < 3000; n++) begin
      cyc($urandom_range(0, 299) == 0,
          $urandom_range(0, 9) != 0,
          $urandom_range(0, 9) < 3,
          $urandom_range(0, 9) < 2,
          $urandom_range(0, 3) == 0,
          $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
